parallel_filter_sched: RTL and testbench

Sequencer for the 8-lane parallel pixel filter. It sweeps a shared read address across all bank memories, waits out the fixed memory-plus-filter latency, and captures the 8 lane results in one clock. It then serializes them, bank 0 first, onto a single valid/ready pixel stream and pulses `done` after the last address. It sits between the frame-level control and the bank memories / filter lanes, replacing free-running enable-driven reading.

---
 rtl/parallel_filter_sched.sv | 145 ++++++++++++++
 tb/tb_parallel_filter_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_filter_sched.sv
// rtl/parallel_filter_sched.sv - address sweep, latency wait, lane capture and pixel serializer for the 8-lane filter
module parallel_filter_sched #(
    parameter int NBANK = 8,
    parameter int DEPTH = 8772,
    parameter int AW    = 14,
    parameter int LAT   = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    output logic [AW-1:0]              mem_addr_o,
    output logic                       mem_rd_o,
    input  logic [8*NBANK-1:0]         lane_pix_i,
    output logic [7:0]                 out_pixel_o,
    output logic [$clog2(NBANK)-1:0]   out_bank_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int BW = $clog2(NBANK);
    localparam int WW = $clog2(LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [AW-1:0]      addr_q;
    logic [WW-1:0]      wait_q;
    logic [BW-1:0]      bank_q;
    logic [8*NBANK-1:0] hold_q;
    logic [7:0]         pix_q;
    logic               mem_rd_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               done_q;

    logic [BW-1:0]      bank_d;
    logic [7:0]         pix_d;

    assign mem_addr_o  = addr_q;
    assign mem_rd_o    = mem_rd_q;
    assign out_pixel_o = pix_q;
    assign out_bank_o  = bank_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    // Next lane to present and its held pixel, so the output register is loaded one beat ahead.
    always_comb begin
        bank_d = bank_q + BW'(1);
        pix_d  = 8'h00;
        for (int k = 0; k < NBANK; k++) begin
            if (BW'(k) == bank_d) begin
                pix_d = hold_q[8*k +: 8];
            end
        end
    end

    // Frame sequencer: every output is a register loaded together with the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wait_q      <= '0;
            bank_q      <= '0;
            hold_q      <= '0;
            pix_q       <= 8'h00;
            mem_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_q  <= S_ISSUE;
                        addr_q   <= '0;
                        mem_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    wait_q  <= WW'(LAT - 1);
                end
                S_WAIT: begin
                    // lane_pix is only trusted on the final latency cycle
                    if (wait_q == '0) begin
                        hold_q      <= lane_pix_i;
                        pix_q       <= lane_pix_i[7:0];
                        bank_q      <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DRAIN;
                    end else begin
                        wait_q <= wait_q - WW'(1);
                    end
                end
                S_DRAIN: begin
                    if (out_ready_i) begin
                        bank_q <= bank_d;
                        if (bank_q == BW'(NBANK - 1)) begin
                            out_valid_q <= 1'b0;
                            if (addr_q == AW'(DEPTH - 1)) begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                addr_q   <= addr_q + AW'(1);
                                mem_rd_q <= 1'b1;
                                state_q  <= S_ISSUE;
                            end
                        end else begin
                            pix_q <= pix_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            // abort wins over whatever the active state scheduled
            if (abort_i && (state_q != S_IDLE)) begin
                state_q     <= S_IDLE;
                mem_rd_q    <= 1'b0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                done_q      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_parallel_filter_sched.sv
// tb/tb_parallel_filter_sched.sv - self-checking bench for parallel_filter_sched
module tb_parallel_filter_sched;

    localparam int NB   = 8;
    localparam int AW   = 14;
    localparam int DEP  = 3;
    localparam int DEP4 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance: DEPTH=3, LAT=2
    logic            rst, start, abort, out_ready;
    logic [8*NB-1:0] lane_pix;
    logic [AW-1:0]   mem_addr;
    logic            mem_rd;
    logic [7:0]      out_pixel;
    logic [2:0]      out_bank;
    logic            out_valid, busy, done;

    // second instance: DEPTH=2, LAT=4
    logic            rst4, start4, abort4, out_ready4;
    logic [8*NB-1:0] lane_pix4;
    logic [AW-1:0]   mem_addr4;
    logic            mem_rd4;
    logic [7:0]      out_pixel4;
    logic [2:0]      out_bank4;
    logic            out_valid4, busy4, done4;

    parallel_filter_sched #(.NBANK(NB), .DEPTH(DEP), .AW(AW), .LAT(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .lane_pix_i(lane_pix),
        .out_pixel_o(out_pixel), .out_bank_o(out_bank), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .busy_o(busy), .done_o(done)
    );

    parallel_filter_sched #(.NBANK(NB), .DEPTH(DEP4), .AW(AW), .LAT(4)) dut4 (
        .clk_i(clk), .rst_i(rst4), .start_i(start4), .abort_i(abort4),
        .mem_addr_o(mem_addr4), .mem_rd_o(mem_rd4), .lane_pix_i(lane_pix4),
        .out_pixel_o(out_pixel4), .out_bank_o(out_bank4), .out_valid_o(out_valid4),
        .out_ready_i(out_ready4), .busy_o(busy4), .done_o(done4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // bank memory + filter model: data valid only exactly LAT cycles after the read
    function automatic logic [8*NB-1:0] lanes(input logic [AW-1:0] a, input logic [7:0] base, input logic ok);
        logic [8*NB-1:0] v;
        for (int k = 0; k < NB; k++) begin
            v[8*k +: 8] = ok ? (base + 8'(a[3:0]) * 8'h10 + 8'(k)) : (8'hE0 | 8'(k));
        end
        return v;
    endfunction

    int            age = 99;
    int            age4 = 99;
    logic [AW-1:0] rd_addr = '0;
    logic [AW-1:0] rd_addr4 = '0;
    assign lane_pix  = lanes(rd_addr, 8'h00, age == 2);
    assign lane_pix4 = lanes(rd_addr4, 8'h80, age4 == 4);

    typedef struct packed {
        logic [7:0] pix;
        logic [2:0] bank;
    } beat_t;

    beat_t sb[$];
    int    rd_log[$];
    int    rd_addr_log[$];
    int    xfer_cnt = 0;
    int    done_cnt = 0;
    int    done_cyc = -1;
    int    stall_cnt = 0;
    bit    prev_stall = 1'b0;

    // main monitor: push expected beats on each read, compare every presented beat
    always @(negedge clk) begin
        beat_t b;
        if (out_valid) begin
            check("sb_has_beat", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                check("beat_pixel", out_pixel, sb[0].pix);
                check("beat_bank", out_bank, sb[0].bank);
            end
            if (out_ready && !rst) begin
                xfer_cnt++;
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (!out_ready) begin
                stall_cnt++;
            end
        end
        if (prev_stall) check("stall_valid_held", out_valid, 1);
        prev_stall = out_valid && !out_ready && !abort && !rst;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (mem_rd) begin
            rd_log.push_back(cyc);
            rd_addr_log.push_back(int'(mem_addr));
            for (int k = 0; k < NB; k++) begin
                b.pix  = 8'(mem_addr[3:0]) * 8'h10 + 8'(k);
                b.bank = 3'(k);
                sb.push_back(b);
            end
            rd_addr = mem_addr;
            age = 0;
        end else if (age < 99) begin
            age++;
        end
    end

    int         rd4_first = -1;
    int         v4_first = -1;
    int         done4_cyc = -1;
    logic [7:0] v4_pix = 8'h00;
    logic [2:0] v4_bank = 3'd7;

    // LAT=4 monitor: first read, first beat, completion
    always @(negedge clk) begin
        if (mem_rd4 && rd4_first < 0) rd4_first = cyc;
        if (out_valid4 && v4_first < 0) begin
            v4_first = cyc;
            v4_pix   = out_pixel4;
            v4_bank  = out_bank4;
        end
        if (done4) done4_cyc = cyc;
        if (mem_rd4) begin
            rd_addr4 = mem_addr4;
            age4 = 0;
        end else if (age4 < 99) begin
            age4++;
        end
    end

    task automatic wait_done(input int d0, input int budget, input bit alt);
        for (int n = 0; n < budget; n++) begin
            if (alt) out_ready = ~out_ready;
            @(posedge clk); #1;
            if (done_cnt != d0) break;
        end
        check("done_seen", 32'(done_cnt != d0), 1);
        out_ready = 1'b1;
    endtask

    typedef struct {
        logic          r, s, a;
        logic          e_busy, e_rd, e_valid, e_done;
        logic [AW-1:0] e_addr;
    } vec_t;

    function automatic vec_t mkv(input logic r, s, a, eb, er, ev, ed);
        vec_t v;
        v.r = r; v.s = s; v.a = a;
        v.e_busy = eb; v.e_rd = er; v.e_valid = ev; v.e_done = ed;
        v.e_addr = '0;
        return v;
    endfunction

    initial begin
        vec_t vt[12];
        int   t, d0, x0;

        vt[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reset
        vt[1]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // idle holds
        vt[2]  = mkv(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // start+abort ignored
        vt[3]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[4]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // ISSUE
        vt[5]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // WAIT 1
        vt[6]  = mkv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // abort in WAIT
        vt[7]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vt[8]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // ISSUE
        vt[9]  = mkv(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // WAIT 1
        vt[10] = mkv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // reset in WAIT
        vt[11] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        rst4 = 1'b1; start4 = 1'b0; abort4 = 1'b0; out_ready4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rst4 = 1'b0;

        // control vectors
        for (int i = 0; i < 12; i++) begin
            rst = vt[i].r; start = vt[i].s; abort = vt[i].a;
            @(posedge clk); #1;
            rst = 1'b0; start = 1'b0; abort = 1'b0;
            check($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
            check($sformatf("vec%0d_mem_rd", i), mem_rd, vt[i].e_rd);
            check($sformatf("vec%0d_valid", i), out_valid, vt[i].e_valid);
            check($sformatf("vec%0d_done", i), done, vt[i].e_done);
            check($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
        end
        sb.delete();
        repeat (3) @(posedge clk);
        #1;

        // full frame, ready=1, with a stray start during WAIT
        rd_log.delete(); rd_addr_log.delete();
        d0 = done_cnt; x0 = xfer_cnt;
        t = cyc; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(d0, 200, 1'b0);
        check("A_done_cycle", done_cyc, t + 34);
        check("A_done_low_after", done, 0);
        check("A_busy_low_after", busy, 0);
        check("A_beats", xfer_cnt - x0, 24);
        check("A_sb_empty", sb.size(), 0);
        check("A_rd_count", rd_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rd_log.size()) begin
                check($sformatf("A_rd%0d_cycle", i), rd_log[i], t + 1 + 11 * i);
                check($sformatf("A_rd%0d_addr", i), rd_addr_log[i], i);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        check("A_single_done", done_cnt - d0, 1);

        // same frame with alternating ready
        rd_log.delete(); rd_addr_log.delete();
        d0 = done_cnt; x0 = xfer_cnt; stall_cnt = 0;
        t = cyc; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(d0, 400, 1'b1);
        check("B_stalls_seen", 32'(stall_cnt > 0), 1);
        check("B_done_cycle", done_cyc, t + 34 + stall_cnt);
        check("B_beats", xfer_cnt - x0, 24);
        check("B_sb_empty", sb.size(), 0);
        check("B_rd_count", rd_log.size(), 3);
        repeat (2) @(posedge clk);
        #1;

        // abort in DRAIN after 3 beats of address 1
        d0 = done_cnt; x0 = xfer_cnt;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int n = 0; n < 100 && (xfer_cnt - x0) < 11; n++) begin
            @(posedge clk); #1;
        end
        check("C_beats_before_abort", xfer_cnt - x0, 11);
        check("C_bank_before_abort", out_bank, 3);
        check("C_addr_before_abort", mem_addr, 1);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        check("C_valid_after_abort", out_valid, 0);
        check("C_busy_after_abort", busy, 0);
        check("C_done_after_abort", done, 0);
        check("C_abort_beat_taken", xfer_cnt - x0, 12);
        sb.delete();
        repeat (4) @(posedge clk);
        #1;
        check("C_idle_busy", busy, 0);
        check("C_no_done", done_cnt - d0, 0);
        t = cyc; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("C_restart_rd", mem_rd, 1);
        check("C_restart_addr", mem_addr, 0);
        wait_done(d0, 200, 1'b0);
        check("C_restart_done_cycle", done_cyc, t + 34);

        // reset for 2 cycles mid-DRAIN
        repeat (2) @(posedge clk);
        #1;
        x0 = xfer_cnt;
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        for (int n = 0; n < 100 && (xfer_cnt - x0) < 13; n++) begin
            @(posedge clk); #1;
        end
        check("E_mid_drain_valid", out_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("E_rst_mem_rd", mem_rd, 0);
        check("E_rst_addr", mem_addr, 0);
        check("E_rst_valid", out_valid, 0);
        check("E_rst_pixel", out_pixel, 0);
        check("E_rst_bank", out_bank, 0);
        check("E_rst_busy", busy, 0);
        check("E_rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("E_rst2_busy", busy, 0);
        sb.delete();
        repeat (5) @(posedge clk);
        #1;
        check("E_stays_idle", busy, 0);
        check("E_no_valid", out_valid, 0);

        // LAT=4 instance
        t = cyc; start4 = 1'b1;
        @(posedge clk); #1; start4 = 1'b0;
        for (int n = 0; n < 100 && done4_cyc < 0; n++) begin
            @(posedge clk); #1;
        end
        check("D_rd_cycle", rd4_first, t + 1);
        check("D_first_valid_gap", v4_first - rd4_first, 5);
        check("D_first_pixel", v4_pix, 8'h80);
        check("D_first_bank", v4_bank, 0);
        check("D_done_cycle", done4_cyc, t + 27);
        check("D_busy_after", busy4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
